// File: rtl/prog_mem_controller_pkg.sv
// prog_mem_controller_pkg: shared state encodings and default widths for the instruction-fetch path.
package prog_mem_controller_pkg;
    localparam int DEFAULT_ADDR_BITS = 8;
    localparam int DEFAULT_DATA_BITS = 16;

    typedef enum logic [1:0] {IDLE, MEM_WAIT, RELEASE} pm_state_e;
    typedef enum logic [1:0] {FETCH_IDLE, FETCH_REQ, FETCH_DONE} fetcher_state_e;
    typedef enum logic [2:0] {CORE_IDLE, CORE_FETCH, CORE_DECODE, CORE_EXECUTE, CORE_DONE} core_state_e;

    function automatic int idx_bits(input int n);
        return n > 1 ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/prog_mem_controller_rr_arbiter.sv
// rr_arbiter: round-robin pick among requesters, searching from the slot after ptr_i.
module rr_arbiter
    import prog_mem_controller_pkg::*;
#(
    parameter int NUM_CONSUMERS = 4,
    parameter int IDX_BITS      = idx_bits(NUM_CONSUMERS)
) (
    input  logic [NUM_CONSUMERS-1:0] req_i,
    input  logic [IDX_BITS-1:0]      ptr_i,
    output logic [NUM_CONSUMERS-1:0] grant_o,
    output logic [IDX_BITS-1:0]      idx_o,
    output logic                     valid_o
);
    logic found;
    int   pos;

    assign valid_o = |req_i;

    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        found   = 1'b0;
        pos     = 0;
        for (int i = 1; i <= NUM_CONSUMERS; i++) begin
            pos = (int'(ptr_i) + i) % NUM_CONSUMERS;
            if (!found && req_i[pos]) begin
                found        = 1'b1;
                grant_o[pos] = 1'b1;
                idx_o        = IDX_BITS'(pos);
            end
        end
    end
endmodule

// File: rtl/prog_mem_controller.sv
// prog_mem_controller: shares one program-memory read port among several instruction fetchers.
module prog_mem_controller
    import prog_mem_controller_pkg::*;
#(
    parameter int NUM_CONSUMERS = 4,
    parameter int ADDR_BITS     = DEFAULT_ADDR_BITS,
    parameter int DATA_BITS     = DEFAULT_DATA_BITS
) (
    input  logic                                    clk,
    input  logic                                    reset,
    input  logic [NUM_CONSUMERS-1:0]                consumer_read_valid,
    input  logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0] consumer_read_address,
    output logic [NUM_CONSUMERS-1:0]                consumer_read_ready,
    output logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0] consumer_read_data,
    output logic                                    mem_read_valid,
    output logic [ADDR_BITS-1:0]                    mem_read_address,
    input  logic                                    mem_read_ready,
    input  logic [DATA_BITS-1:0]                    mem_read_data
);
    localparam int IDX_BITS = idx_bits(NUM_CONSUMERS);

    pm_state_e                               state_q, state_d;
    logic [IDX_BITS-1:0]                     grant_idx_q, grant_idx_d, rr_ptr_q, rr_ptr_d, arb_idx;
    logic [NUM_CONSUMERS-1:0]                arb_grant, ready_q, ready_d;
    logic                                    arb_any, mem_valid_q, mem_valid_d;
    logic [ADDR_BITS-1:0]                    mem_addr_q, mem_addr_d, sel_addr;
    logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0] data_q, data_d;

    rr_arbiter #(
        .NUM_CONSUMERS(NUM_CONSUMERS),
        .IDX_BITS     (IDX_BITS)
    ) u_arb (
        .req_i  (consumer_read_valid),
        .ptr_i  (rr_ptr_q),
        .grant_o(arb_grant),
        .idx_o  (arb_idx),
        .valid_o(arb_any)
    );

    // The one-hot grant turns the address select into a plain AND-OR tree.
    always_comb begin
        sel_addr = '0;
        for (int i = 0; i < NUM_CONSUMERS; i++)
            sel_addr |= consumer_read_address[i] & {ADDR_BITS{arb_grant[i]}};
    end

    always_comb begin
        state_d     = state_q;
        grant_idx_d = grant_idx_q;
        rr_ptr_d    = rr_ptr_q;
        mem_valid_d = mem_valid_q;
        mem_addr_d  = mem_addr_q;
        ready_d     = '0;
        data_d      = data_q;
        case (state_q)
            IDLE: if (arb_any) begin
                grant_idx_d = arb_idx;
                rr_ptr_d    = arb_idx;
                mem_addr_d  = sel_addr;
                mem_valid_d = 1'b1;
                state_d     = MEM_WAIT;
            end
            MEM_WAIT: if (mem_read_ready) begin
                mem_valid_d          = 1'b0;
                data_d[grant_idx_q]  = mem_read_data;
                ready_d[grant_idx_q] = 1'b1;
                state_d              = RELEASE;
            end
            RELEASE: state_d = consumer_read_valid[grant_idx_q] ? RELEASE : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            grant_idx_q <= '0;
            rr_ptr_q    <= IDX_BITS'(NUM_CONSUMERS - 1);
            mem_valid_q <= 1'b0;
            mem_addr_q  <= '0;
            ready_q     <= '0;
            data_q      <= '0;
        end else begin
            state_q     <= state_d;
            grant_idx_q <= grant_idx_d;
            rr_ptr_q    <= rr_ptr_d;
            mem_valid_q <= mem_valid_d;
            mem_addr_q  <= mem_addr_d;
            ready_q     <= ready_d;
            data_q      <= data_d;
        end
    end

    assign consumer_read_ready = ready_q;
    assign consumer_read_data  = data_q;
    assign mem_read_valid      = mem_valid_q;
    assign mem_read_address    = mem_addr_q;
endmodule

// File: tb/tb_prog_mem_controller.sv
// tb_prog_mem_controller: randomized fetch traffic against a round-robin service model.
module tb_prog_mem_controller;
    localparam int N = 4;

    logic                clk = 1'b0;
    logic                reset = 1'b0;
    logic [N-1:0]        vld = '0;
    logic [N-1:0][7:0]   addr = '0;
    logic [N-1:0]        rdy;
    logic [N-1:0][15:0]  rdata;
    logic                mv;
    logic [7:0]          maddr;
    logic                mrr = 1'b0;
    logic [15:0]         mrd = '0;

    always #5 clk = ~clk;

    prog_mem_controller #(.NUM_CONSUMERS(N), .ADDR_BITS(8), .DATA_BITS(16)) dut (
        .clk                  (clk),
        .reset                (reset),
        .consumer_read_valid  (vld),
        .consumer_read_address(addr),
        .consumer_read_ready  (rdy),
        .consumer_read_data   (rdata),
        .mem_read_valid       (mv),
        .mem_read_address     (maddr),
        .mem_read_ready       (mrr),
        .mem_read_data        (mrd)
    );

    int                 total = 0, bad = 0;
    logic [15:0]        mem_arr [256];
    logic [N-1:0][15:0] exp_data;
    int                 last, exp_grant, stall, delay_cfg, cyc = 0, pulse_cyc;
    bit                 expect_pulse, prev_mv;
    logic [7:0]         held;
    logic [N-1:0]       raise_next;
    int                 rereq_left [N];
    int                 order [$];

    task automatic model_reset();
        last         = N - 1;
        exp_data     = '0;
        exp_grant    = -1;
        expect_pulse = 1'b0;
        prev_mv      = 1'b0;
        raise_next   = '0;
        stall        = 0;
        for (int i = 0; i < N; i++) rereq_left[i] = 0;
        order.delete();
    endtask

    task automatic fill_mem();
        for (int i = 0; i < 256; i++) mem_arr[i] = 16'($urandom);
    endtask

    // Memory responder plus consumers; a served consumer drops valid and may re-raise it one cycle later.
    task automatic run_traffic(input int budget);
        int           c = 0;
        int           j;
        logic [N-1:0] exp_rdy;
        while ((vld != 0 || raise_next != 0 || exp_grant >= 0) && c < budget) begin
            @(posedge clk); #1;
            c++; cyc++;
            exp_rdy = '0;
            if (expect_pulse) exp_rdy[exp_grant] = 1'b1;
            total++;
            if (rdy !== exp_rdy) begin bad++; $display("FAIL ready: got %b want %b cycle %0d", rdy, exp_rdy, cyc); end
            total++;
            if (rdata !== exp_data) begin bad++; $display("FAIL data: got %h want %h cycle %0d", rdata, exp_data, cyc); end
            if (!expect_pulse && mv && !prev_mv) begin
                j = -1;
                for (int i = 1; i <= N; i++) if (j < 0 && vld[(last + i) % N]) j = (last + i) % N;
                total++;
                if (j < 0 || exp_grant >= 0) begin
                    bad++; $display("FAIL grant_unexpected: mem_read_valid rose, model grant %0d pending %0d", j, exp_grant);
                end else if (maddr !== addr[j]) begin
                    bad++; $display("FAIL grant_addr: got %h want %h (consumer %0d)", maddr, addr[j], j);
                end
                if (j >= 0) begin exp_grant = j; last = j; held = addr[j]; stall = 0; end
            end else if (mv) begin
                total++;
                if (maddr !== held) begin bad++; $display("FAIL addr_stable: got %h want %h", maddr, held); end
            end
            prev_mv = mv;
            vld |= raise_next;
            raise_next = '0;
            if (expect_pulse) begin
                total++;
                if (mv !== 1'b0) begin bad++; $display("FAIL mem_valid_drop: got %b want 0", mv); end
                order.push_back(exp_grant);
                pulse_cyc = cyc;
                vld[exp_grant] = 1'b0;
                if (rereq_left[exp_grant] > 0) begin
                    rereq_left[exp_grant]--;
                    raise_next[exp_grant] = 1'b1;
                end
                exp_grant    = -1;
                expect_pulse = 1'b0;
            end
            mrr = 1'b0;
            if (mv && exp_grant >= 0) begin
                if (stall >= delay_cfg) begin
                    mrr = 1'b1;
                    mrd = mem_arr[held];
                    exp_data[exp_grant] = mrd;
                    expect_pulse = 1'b1;
                end else stall++;
            end
            if (exp_grant >= 0 && !vld[exp_grant]) begin
                bad++; $display("FAIL illegal_drop: consumer %0d dropped valid while granted", exp_grant);
            end
        end
        mrr = 1'b0;
        total++;
        if (vld != 0 || raise_next != 0 || exp_grant >= 0) begin
            bad++; $display("FAIL timeout: pending valid %b grant %0d after %0d cycles", vld, exp_grant, c);
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0; vld = '0; mrr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total++; if (rdy !== '0) begin bad++; $display("FAIL reset_ready: got %b want 0", rdy); end
        total++; if (rdata !== '0) begin bad++; $display("FAIL reset_data: got %h want 0", rdata); end
        total++; if (mv !== 1'b0) begin bad++; $display("FAIL reset_mem_valid: got %b want 0", mv); end
        total++; if (maddr !== '0) begin bad++; $display("FAIL reset_mem_addr: got %h want 0", maddr); end
        reset = 1'b1;
        model_reset();
    endtask

    task automatic test_single();
        int start;
        test_reset();
        fill_mem();
        mem_arr[8'h10] = 16'h1234;
        delay_cfg = 1;
        addr[2] = 8'h10;
        vld = 4'b0100;
        start = cyc;
        run_traffic(20);
        total++; if (order.size() != 1 || order[0] != 2) begin bad++; $display("FAIL single_order: got %p want '{2}", order); end
        total++; if (rdata[2] !== 16'h1234) begin bad++; $display("FAIL single_data: got %h want 1234", rdata[2]); end
        total++; if (pulse_cyc - start != 3) begin bad++; $display("FAIL single_latency: got %0d want 3", pulse_cyc - start); end
    endtask

    task automatic test_latency();
        int start;
        delay_cfg = 0;
        addr[1] = 8'($urandom);
        vld = 4'b0010;
        start = cyc;
        run_traffic(20);
        total++; if (pulse_cyc - start != 2) begin bad++; $display("FAIL min_latency: got %0d want 2", pulse_cyc - start); end
    endtask

    task automatic test_all_four();
        test_reset();
        fill_mem();
        delay_cfg = 1;
        for (int i = 0; i < N; i++) addr[i] = 8'(8'h40 + 8'(i * 3));
        vld = '1;
        run_traffic(60);
        total++;
        if (order.size() != 4 || order[0] != 0 || order[1] != 1 || order[2] != 2 || order[3] != 3) begin
            bad++; $display("FAIL all_four_order: got %p want '{0,1,2,3}", order);
        end
    endtask

    task automatic test_fairness();
        test_reset();
        delay_cfg = 0;
        addr[0] = 8'h01; addr[3] = 8'h33;
        vld = 4'b1001;
        rereq_left[0] = 2;
        run_traffic(60);
        total++;
        if (order.size() != 4 || order[0] != 0 || order[1] != 3) begin
            bad++; $display("FAIL fairness: got %p want 0 then 3 first", order);
        end
    endtask

    task automatic test_stall();
        int k;
        delay_cfg = 20;
        k = int'($urandom_range(0, N - 1));
        addr[k] = 8'($urandom);
        vld[k] = 1'b1;
        run_traffic(60);
        total++; if (order.size() == 0 || order[order.size() - 1] != k) begin bad++; $display("FAIL stall_served: got %p want last %0d", order, k); end
    endtask

    task automatic test_spurious();
        vld = '0;
        mrr = 1'b1;
        mrd = 16'hdead;
        repeat (3) begin
            @(posedge clk); #1;
            total++; if (rdy !== '0) begin bad++; $display("FAIL spurious_ready: got %b want 0", rdy); end
            total++; if (mv !== 1'b0) begin bad++; $display("FAIL spurious_mem_valid: got %b want 0", mv); end
            total++; if (rdata !== exp_data) begin bad++; $display("FAIL spurious_data: got %h want %h", rdata, exp_data); end
        end
        mrr = 1'b0;
        delay_cfg = 0;
        addr[3] = 8'($urandom);
        vld = 4'b1000;
        run_traffic(20);
    endtask

    task automatic test_reset_mid();
        int w = 0;
        test_reset();
        fill_mem();
        delay_cfg = 0;
        addr[1] = 8'($urandom);
        vld = 4'b0010;
        run_traffic(20);
        addr[0] = 8'h0a; addr[3] = 8'h3c;
        vld = 4'b1001;
        do begin @(posedge clk); #1; w++; end while (!mv && w < 5);
        total++;
        if (mv !== 1'b1 || maddr !== 8'h3c) begin bad++; $display("FAIL pre_reset_grant: valid %b addr %h want 1 3c", mv, maddr); end
        @(posedge clk); #3;
        reset = 1'b0;
        #1;
        total++; if (rdy !== '0 || rdata !== '0) begin bad++; $display("FAIL async_reset_consumer: ready %b data %h want 0", rdy, rdata); end
        total++; if (mv !== 1'b0 || maddr !== '0) begin bad++; $display("FAIL async_reset_mem: valid %b addr %h want 0", mv, maddr); end
        @(posedge clk); #1;
        reset = 1'b1;
        model_reset();
        run_traffic(40);
        total++;
        if (order.size() != 2 || order[0] != 0 || order[1] != 3) begin bad++; $display("FAIL reset_rearb: got %p want '{0,3}", order); end
    endtask

    task automatic test_random();
        for (int r = 0; r < 30; r++) begin
            fill_mem();
            delay_cfg = int'($urandom_range(0, 3));
            for (int i = 0; i < N; i++) begin
                addr[i] = 8'($urandom);
                rereq_left[i] = int'($urandom_range(0, 1));
            end
            vld = N'($urandom);
            run_traffic(400);
        end
    endtask

    initial begin
        model_reset();
        delay_cfg = 0;
        test_reset();
        test_single();
        test_latency();
        test_all_four();
        test_fairness();
        test_stall();
        test_spurious();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/prog_mem_controller.md
PROG_MEM_CONTROLLER -- requirements
Module: prog_mem_controller

Interface
REQ-001 SHALL have parameter NUM_CONSUMERS, default 4: number of fetchers served.
REQ-002 SHALL have parameter ADDR_BITS, default 8: program memory address width.
REQ-003 SHALL have parameter DATA_BITS, default 16: instruction width.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port consumer_read_valid  input  [NUM_CONSUMERS]  per-fetcher request; held high until serviced.
REQ-007 SHALL have port consumer_read_address  input  [NUM_CONSUMERS][ADDR_BITS]  per-fetcher PC; stable while valid.
REQ-008 SHALL have port consumer_read_ready  output  [NUM_CONSUMERS]  per-fetcher one-cycle completion pulse.
REQ-009 SHALL have port consumer_read_data  output  [NUM_CONSUMERS][DATA_BITS]  per-fetcher instruction; valid while ready is high.
REQ-010 SHALL have port mem_read_valid  output  1  request to external program memory.
REQ-011 SHALL have port mem_read_address  output  [ADDR_BITS]  external memory address.
REQ-012 SHALL have port mem_read_ready  input  1  external memory response strobe.
REQ-013 SHALL have port mem_read_data  input  [DATA_BITS]  external memory instruction, sampled when mem_read_ready is high.

Function
REQ-014 SHALL run a three-state FSM: IDLE, MEM_WAIT, RELEASE.
REQ-015 In IDLE, when any consumer_read_valid bit is high, SHALL grant one consumer, register its address onto mem_read_address, assert mem_read_valid, and enter MEM_WAIT on the next edge.
REQ-016 Grant SHALL be round-robin: search starts at (last granted index + 1) mod NUM_CONSUMERS; after reset the search starts at index 0.
REQ-017 In MEM_WAIT with mem_read_ready high, SHALL deassert mem_read_valid, drive mem_read_data onto the granted consumer's consumer_read_data, pulse its consumer_read_ready for exactly one cycle, and enter RELEASE.
REQ-018 In RELEASE, SHALL wait until the granted consumer's consumer_read_valid is low, then return to IDLE; no new grant is issued in the same cycle.
REQ-019 consumer_read_ready SHALL be one-hot or all-zero in every cycle; non-granted consumers always see ready low.
REQ-020 consumer_read_data for a consumer SHALL hold its last delivered value until that consumer is serviced again.
REQ-021 Minimum latency SHALL be 3 cycles: valid seen in IDLE, then mem_read_valid, then a same-cycle mem_read_ready, then the consumer ready pulse.
REQ-022 A consumer's request SHALL be serviced within NUM_CONSUMERS grants of it being raised: no starvation.
REQ-023 When mem_read_ready is high outside MEM_WAIT, the block SHALL ignore it.
REQ-024 A consumer dropping valid while granted in MEM_WAIT is illegal; the bench SHALL flag it, and the RTL need not define the behaviour.

Reset
REQ-025 On reset low, the block SHALL asynchronously force state=IDLE, mem_read_valid=0, mem_read_address=0, all consumer_read_ready=0, all consumer_read_data=0, grant index=0, and round-robin pointer=NUM_CONSUMERS-1.
REQ-026 Reset asserted mid-transaction SHALL abandon the transaction; after release the block SHALL re-arbitrate from index 0 with no ready pulse for the aborted request.

Structure
REQ-027 The FSM state typedef SHALL live in the shared package alongside the fetcher and core state encodings.
REQ-028 Default ADDR_BITS and DATA_BITS constants SHALL live in the same shared package.
REQ-029 Arbitration SHALL be one sub-module, rr_arbiter, parameterised by NUM_CONSUMERS, taking request vector and pointer and returning a one-hot grant plus index.

Verification
REQ-030 Single request: consumer 2 raises valid, address 0x10, memory answers 0x1234 with 1-cycle delay -> mem_read_address=0x10, consumer_read_ready[2] pulses once, consumer_read_data[2]=0x1234, others silent.
REQ-031 All four consumers request simultaneously -> grants in order 0,1,2,3, each receiving its own address's data, and never two ready bits high at once.
REQ-032 Round-robin fairness: consumer 0 re-requests immediately after each service while consumer 3 waits -> consumer 3 is granted before consumer 0's second grant.
REQ-033 Memory stalls 20 cycles -> mem_read_valid and mem_read_address stay stable throughout, with no consumer ready until mem_read_ready.
REQ-034 Reset low during MEM_WAIT -> all outputs are zero immediately (before the next clock), no ready pulse follows, and the pending request re-arbitrates from index 0 after release.
REQ-035 Spurious mem_read_ready in IDLE -> no consumer ready pulse and no state change.
